mul4_vector_scorer: RTL and testbench

// - Sequential fitness scorer at the consumer end of the bit-sliced 2x2-bit multiplier interface.
// - Drives one exhaustive stimulus vector into a candidate multiplier on a1/a0/b1/b0.
// - Captures the candidate's y3..y0 and compares all 64 output bits against a golden product.
// - Returns a match count through a valid/ready result handshake; sits between the evolutionary driver and each candidate.

---
 rtl/mul4_vector_scorer.sv | 169 ++++++++++++++++
 tb/tb_mul4_vector_scorer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul4_vector_scorer.sv
// Fitness scorer for a bit-sliced 2x2 multiplier candidate: drives the exhaustive 16-lane stimulus,
// captures y3..y0 after SETTLE cycles and returns the count of matching bits. Option: MUL4_SCORE_MASK_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start, stimulus zero
// ST_SETTLE | stimulus held while the candidate settles (SETTLE cycles)
// ST_CAPTURE| one cycle, y3..y0 registered, accumulator cleared
// ST_SCORE  | four cycles, one golden word compared per cycle
// ST_DONE   | score presented with res_valid until res_ready
module mul4_vector_scorer #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic [15:0] a1,
  output logic [15:0] a0,
  output logic [15:0] b1,
  output logic [15:0] b0,
  input  logic [15:0] y3,
  input  logic [15:0] y2,
  input  logic [15:0] y1,
  input  logic [15:0] y0,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [6:0]  score
`ifdef MUL4_SCORE_MASK_EN
  ,
  output logic [3:0]  err_mask,
  output logic        perfect
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_SCORE,
    ST_DONE
  } state_t;

  // Lane i carries A=i[3:2], B=i[1:0]; golden words are the matching product bits.
  localparam logic [15:0] STIM_A1 = 16'hFF00;
  localparam logic [15:0] STIM_A0 = 16'hF0F0;
  localparam logic [15:0] STIM_B1 = 16'hCCCC;
  localparam logic [15:0] STIM_B0 = 16'hAAAA;
  localparam logic [15:0] GOLD_0  = 16'hA0A0;
  localparam logic [15:0] GOLD_1  = 16'h6AC0;
  localparam logic [15:0] GOLD_2  = 16'h4C00;
  localparam logic [15:0] GOLD_3  = 16'h8000;
  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE - 1);

  state_t      state;
  logic [3:0]  settle_cnt;
  logic [1:0]  widx;
  logic [15:0] cap [4];
  logic [6:0]  acc;
  logic [15:0] gold_w;
  logic [15:0] match_w;
  logic [6:0]  acc_next;
  logic [3:0]  mask_q;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'b0, v[i]};
    return c;
  endfunction

  always_comb begin
    gold_w = GOLD_0;
    case (widx)
      2'd0: gold_w = GOLD_0;
      2'd1: gold_w = GOLD_1;
      2'd2: gold_w = GOLD_2;
      2'd3: gold_w = GOLD_3;
      default: gold_w = GOLD_0;
    endcase
    match_w  = ~(cap[widx] ^ gold_w);
    acc_next = acc + {2'b0, popcount16(match_w)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      widx       <= '0;
      for (int k = 0; k < 4; k++) cap[k] <= '0;
      acc        <= '0;
      mask_q     <= '0;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
      score      <= '0;
      a1         <= '0;
      a0         <= '0;
      b1         <= '0;
      b0         <= '0;
`ifdef MUL4_SCORE_MASK_EN
      perfect    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_SETTLE;
            settle_cnt <= SETTLE_LOAD;
            busy       <= 1'b1;
            a1         <= STIM_A1;
            a0         <= STIM_A0;
            b1         <= STIM_B1;
            b0         <= STIM_B0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == 4'd0) state <= ST_CAPTURE;
          else settle_cnt <= settle_cnt - 4'd1;
        end
        ST_CAPTURE: begin
          cap[0] <= y0;
          cap[1] <= y1;
          cap[2] <= y2;
          cap[3] <= y3;
          acc    <= '0;
          mask_q <= '0;
          widx   <= '0;
          a1     <= '0;
          a0     <= '0;
          b1     <= '0;
          b0     <= '0;
          state  <= ST_SCORE;
        end
        ST_SCORE: begin
          acc          <= acc_next;
          widx         <= widx + 2'd1;
          mask_q[widx] <= (match_w != 16'hFFFF);
          if (widx == 2'd3) begin
            state     <= ST_DONE;
            res_valid <= 1'b1;
            score     <= acc_next;
`ifdef MUL4_SCORE_MASK_EN
            perfect   <= (acc_next == 7'd64);
`endif
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef MUL4_SCORE_MASK_EN
            perfect   <= 1'b0;
`endif
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUL4_SCORE_MASK_EN
  assign err_mask = mask_q;
`endif

endmodule

// File: tb/tb_mul4_vector_scorer.sv
// Bench for mul4_vector_scorer: three instances (SETTLE 2, 1, 15) each driving a configurable
// candidate multiplier; scores checked against a lane-level reference model. Honours MUL4_SCORE_MASK_EN.
module tb_mul4_vector_scorer;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic res_ready = 1'b0;

  logic [15:0] a1_s [NI];
  logic [15:0] a0_s [NI];
  logic [15:0] b1_s [NI];
  logic [15:0] b0_s [NI];
  logic [NI-1:0] busy_s;
  logic [NI-1:0] valid_s;
  logic [6:0] score_s [NI];
`ifdef MUL4_SCORE_MASK_EN
  logic [3:0] mask_s [NI];
  logic [NI-1:0] perfect_s;
`endif

  // Candidate corruption: y_k = ((ideal_k & and_m) | or_m) ^ xor_m, or random junk outside capture.
  logic [15:0] and_m [4];
  logic [15:0] or_m [4];
  logic [15:0] xor_m [4];
  logic [15:0] junk_val [4];
  logic junk_en = 1'b0;
  int edges = 0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) edges <= start ? 0 : edges + 1;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) junk_val[k] <= 16'($urandom);
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int S = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    logic [15:0] y0, y1, y2, y3;
    logic [3:0]  p;
    logic [15:0] w [4];

    always_comb begin
      p = '0;
      for (int k = 0; k < 4; k++) w[k] = '0;
      for (int i = 0; i < 16; i++) begin
        p = {2'b0, a1_s[g][i], a0_s[g][i]} * {2'b0, b1_s[g][i], b0_s[g][i]};
        for (int k = 0; k < 4; k++) w[k][i] = p[k];
      end
      if (junk_en && edges != S) begin
        y0 = junk_val[0];
        y1 = junk_val[1];
        y2 = junk_val[2];
        y3 = junk_val[3];
      end else begin
        y0 = ((w[0] & and_m[0]) | or_m[0]) ^ xor_m[0];
        y1 = ((w[1] & and_m[1]) | or_m[1]) ^ xor_m[1];
        y2 = ((w[2] & and_m[2]) | or_m[2]) ^ xor_m[2];
        y3 = ((w[3] & and_m[3]) | or_m[3]) ^ xor_m[3];
      end
    end

    mul4_vector_scorer #(.SETTLE(S)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .busy     (busy_s[g]),
      .a1       (a1_s[g]),
      .a0       (a0_s[g]),
      .b1       (b1_s[g]),
      .b0       (b0_s[g]),
      .y3       (y3),
      .y2       (y2),
      .y1       (y1),
      .y0       (y0),
      .res_valid(valid_s[g]),
      .res_ready(res_ready),
      .score    (score_s[g])
`ifdef MUL4_SCORE_MASK_EN
      ,
      .err_mask (mask_s[g]),
      .perfect  (perfect_s[g])
`endif
    );
  end

  function automatic int settle_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
  endfunction

  // Reference: golden bit of lane i, word k is bit k of (i/4)*(i%4); candidate bit derived from it.
  function automatic void ref_model(output int sc, output logic [3:0] m);
    int prod;
    logic gb, cb;
    sc = 0;
    m  = 4'h0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) begin
        prod = (i / 4) * (i % 4);
        gb = ((prod >> k) & 1) == 1;
        cb = ((gb & and_m[k][i]) | or_m[k][i]) ^ xor_m[k][i];
        if (cb == gb) sc++;
        else m[k] = 1'b1;
      end
    end
  endfunction

  task automatic set_cand(input logic [15:0] am, input logic [15:0] om, input logic [15:0] xm);
    for (int k = 0; k < 4; k++) begin
      and_m[k] = am;
      or_m[k]  = om;
      xor_m[k] = xm;
    end
  endtask

  task automatic run_eval(input string name, input int hold, input bit pulse_mid);
    int exp_sc;
    logic [3:0] exp_m;
    int lat [NI];
    bit got [NI];
    int ndone;
    ref_model(exp_sc, exp_m);
    for (int g = 0; g < NI; g++) begin
      lat[g] = 0;
      got[g] = 1'b0;
    end
    ndone = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy_s !== 3'b111) begin
      fails++;
      $display("FAIL %s busy_after_start got=%b want=111", name, busy_s);
    end
    for (int k = 1; k <= 40 && ndone < NI; k++) begin
      if (pulse_mid && (k == 1 || k == 5 || k == 8)) start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int g = 0; g < NI; g++) begin
        if (!got[g] && valid_s[g] === 1'b1) begin
          got[g] = 1'b1;
          lat[g] = k;
          ndone++;
        end
      end
    end
    for (int g = 0; g < NI; g++) begin
      tests++;
      if (!got[g] || lat[g] != settle_of(g) + 5) begin
        fails++;
        $display("FAIL %s latency[S=%0d] got=%0d (seen=%0d) want=%0d", name, settle_of(g), lat[g], got[g], settle_of(g) + 5);
      end
      tests++;
      if (score_s[g] !== 7'(exp_sc)) begin
        fails++;
        $display("FAIL %s score[S=%0d] got=%0d want=%0d", name, settle_of(g), score_s[g], exp_sc);
      end
`ifdef MUL4_SCORE_MASK_EN
      tests++;
      if (mask_s[g] !== exp_m) begin
        fails++;
        $display("FAIL %s err_mask[S=%0d] got=%b want=%b", name, settle_of(g), mask_s[g], exp_m);
      end
      tests++;
      if (perfect_s[g] !== (exp_sc == 64)) begin
        fails++;
        $display("FAIL %s perfect[S=%0d] got=%b want=%b", name, settle_of(g), perfect_s[g], exp_sc == 64);
      end
`endif
    end
    repeat (hold) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        tests++;
        if (valid_s[g] !== 1'b1 || score_s[g] !== 7'(exp_sc)) begin
          fails++;
          $display("FAIL %s hold[S=%0d] valid=%b score=%0d want valid=1 score=%0d", name, settle_of(g), valid_s[g], score_s[g], exp_sc);
        end
      end
    end
    // Handshake with start raised in the same cycle: the start must be dropped.
    res_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    tests++;
    if (valid_s !== 3'b000 || busy_s !== 3'b000) begin
      fails++;
      $display("FAIL %s release valid=%b busy=%b want 000/000", name, valid_s, busy_s);
    end
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      tests++;
      if (busy_s[g] !== 1'b0 || {a1_s[g], a0_s[g], b1_s[g], b0_s[g]} !== 64'h0) begin
        fails++;
        $display("FAIL %s idle_after[S=%0d] busy=%b stim=%h want busy=0 stim=0", name, settle_of(g), busy_s[g], {a1_s[g], a0_s[g], b1_s[g], b0_s[g]});
      end
    end
  endtask

  task automatic test_reset();
    set_cand(16'hFFFF, 16'h0000, 16'h0000);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      tests++;
      if (busy_s[g] !== 1'b0 || valid_s[g] !== 1'b0 || score_s[g] !== 7'd0 ||
          {a1_s[g], a0_s[g], b1_s[g], b0_s[g]} !== 64'h0) begin
        fails++;
        $display("FAIL reset[S=%0d] busy=%b valid=%b score=%0d stim=%h want all zero", settle_of(g), busy_s[g], valid_s[g], score_s[g], {a1_s[g], a0_s[g], b1_s[g], b0_s[g]});
      end
`ifdef MUL4_SCORE_MASK_EN
      tests++;
      if (mask_s[g] !== 4'h0 || perfect_s[g] !== 1'b0) begin
        fails++;
        $display("FAIL reset_mask[S=%0d] mask=%b perfect=%b want 0000/0", settle_of(g), mask_s[g], perfect_s[g]);
      end
`endif
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fixed_candidates();
    set_cand(16'hFFFF, 16'h0000, 16'h0000);
    run_eval("ideal", 2, 1'b0);
    set_cand(16'h0000, 16'h0000, 16'h0000);
    run_eval("all_zero", 0, 1'b0);
    set_cand(16'hFFFF, 16'hFFFF, 16'h0000);
    run_eval("all_ones", 0, 1'b0);
    set_cand(16'hFFFF, 16'h0000, 16'hFFFF);
    run_eval("inverted", 0, 1'b0);
    set_cand(16'hFFFF, 16'h0000, 16'h0000);
    and_m[2] = 16'h0000;
    run_eval("y2_zero_hold", 10, 1'b0);
  endtask

  task automatic test_ignore_start();
    set_cand(16'hFFFF, 16'h0000, 16'h0000);
    xor_m[1] = 16'h0101;
    run_eval("start_midrun", 1, 1'b1);
  endtask

  task automatic test_y_only_in_capture();
    set_cand(16'hFFFF, 16'h0000, 16'h0000);
    junk_en = 1'b1;
    run_eval("y_junk_outside_capture", 1, 1'b0);
    junk_en = 1'b0;
  endtask

  task automatic test_abort();
    set_cand(16'hFFFF, 16'h0000, 16'h0000);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      tests++;
      if (busy_s[g] !== 1'b0 || valid_s[g] !== 1'b0 || {a1_s[g], a0_s[g], b1_s[g], b0_s[g]} !== 64'h0) begin
        fails++;
        $display("FAIL abort[S=%0d] busy=%b valid=%b stim=%h want zeros", settle_of(g), busy_s[g], valid_s[g], {a1_s[g], a0_s[g], b1_s[g], b0_s[g]});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      tests++;
      if (valid_s !== 3'b000) begin
        fails++;
        $display("FAIL abort_no_valid valid=%b want 000", valid_s);
      end
    end
    run_eval("after_abort", 0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        and_m[k] = 16'($urandom) | 16'($urandom);
        or_m[k]  = 16'($urandom) & 16'($urandom) & 16'($urandom);
        xor_m[k] = 16'($urandom) & 16'($urandom);
      end
      run_eval("random", r % 3, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_candidates();
    test_ignore_start();
    test_y_only_in_capture();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
